// File: rtl/uart_alu_ctrl.sv
// Command sequencer between a UART receiver, an ALU and a UART transmitter.
// Collects A, B and opcode bytes, captures the ALU result and requests one transmit per command.
module uart_alu_ctrl #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int TIMEOUT = 100000
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_timeout,
   output logic               o_overrun,
   output logic [5:0]         o_state_dbg
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_ONE = TW'(1);

   typedef enum logic [5:0] {
      ST_WAIT_A  = 6'b000001,
      ST_WAIT_B  = 6'b000010,
      ST_WAIT_OP = 6'b000100,
      ST_EXEC    = 6'b001000,
      ST_SEND    = 6'b010000,
      ST_WAIT_TX = 6'b100000
   } state_t;

   state_t             state_q;
   logic [TW-1:0]      timer_q;
   logic [NB_DATA-1:0] alu_a_q;
   logic [NB_DATA-1:0] alu_b_q;
   logic [NB_OP-1:0]   alu_op_q;
   logic [NB_DATA-1:0] tx_data_q;
   logic               tx_start_q;
   logic               busy_q;
   logic               timeout_q;
   logic               overrun_q;

   // Outputs are registered alongside the state so every pulse lines up with its transition.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_WAIT_A;
         timer_q    <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
         case (state_q)
            ST_WAIT_A: begin
               timer_q <= '0;
               if (i_rx_done) begin
                  alu_a_q <= i_rx_data;
                  state_q <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               // An arriving byte wins over an expiring timer.
               if (i_rx_done) begin
                  alu_b_q <= i_rx_data;
                  timer_q <= '0;
                  state_q <= ST_WAIT_OP;
               end else if (timer_q == TMAX) begin
                  timer_q   <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_WAIT_A;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            ST_WAIT_OP: begin
               if (i_rx_done) begin
                  alu_op_q <= i_rx_data[NB_OP-1:0];
                  timer_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_EXEC;
               end else if (timer_q == TMAX) begin
                  timer_q   <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_WAIT_A;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            ST_EXEC: begin
               overrun_q  <= i_rx_done;
               tx_data_q  <= i_alu_result;
               tx_start_q <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               overrun_q <= i_rx_done;
               state_q   <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               overrun_q <= i_rx_done;
               if (i_tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_A;
               end
            end
            default: begin
               timer_q <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_WAIT_A;
            end
         endcase
      end
   end

   assign o_alu_a     = alu_a_q;
   assign o_alu_b     = alu_b_q;
   assign o_alu_op    = alu_op_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_busy      = busy_q;
   assign o_timeout   = timeout_q;
   assign o_overrun   = overrun_q;
   assign o_state_dbg = state_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed and randomized checks of uart_alu_ctrl against a command-level reference model.
module tb_uart_alu_ctrl;
   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         i_rst_n;
   logic [7:0]   i_rx_data;
   logic         i_rx_done;
   logic [7:0]   i_alu_result;
   logic         i_tx_done;
   logic [7:0]   o_alu_a;
   logic [7:0]   o_alu_b;
   logic [5:0]   o_alu_op;
   logic [7:0]   o_tx_data;
   logic         o_tx_start;
   logic         o_busy;
   logic         o_timeout;
   logic         o_overrun;
   logic [5:0]   o_state_dbg;

   always #5 clk = ~clk;

   uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
      .o_tx_start(o_tx_start), .o_busy(o_busy), .o_timeout(o_timeout),
      .o_overrun(o_overrun), .o_state_dbg(o_state_dbg)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   always_comb i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

   int vectors = 0;
   int miscompares = 0;
   int tmo_seen = 0, ovr_seen = 0, start_seen = 0;
   int tmo_exp = 0, ovr_exp = 0, start_exp = 0;
   logic [7:0] exp_a = 8'h00, exp_b = 8'h00, exp_tx = 8'h00;
   logic [5:0] exp_op = 6'h00;

   always @(negedge clk) begin
      if (i_rst_n) begin
         if (o_timeout)  tmo_seen++;
         if (o_overrun)  ovr_seen++;
         if (o_tx_start) start_seen++;
      end
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] d);
      i_rx_data = d;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
      i_rx_data = 8'($urandom);
   endtask

   task automatic check_operands(input string tag);
      check8({tag, "_a"}, o_alu_a, exp_a);
      check8({tag, "_b"}, o_alu_b, exp_b);
      check8({tag, "_op"}, {2'b00, o_alu_op}, {2'b00, exp_op});
      check8({tag, "_tx"}, o_tx_data, exp_tx);
   endtask

   // One full command; gap = idle cycles between bytes (15 lands on the timer's last cycle).
   task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input bit overrun, input int txw);
      send_byte(a);
      exp_a = a;
      check8("a_latch", o_alu_a, exp_a);
      check8("b_hold", o_alu_b, exp_b);
      check1("busy_wait_b", o_busy, 1'b0);
      idle(gap);
      send_byte(b);
      exp_b = b;
      check8("b_latch", o_alu_b, exp_b);
      check1("no_tmo_b", o_timeout, 1'b0);
      idle(gap);
      send_byte(opb);
      exp_op = opb[5:0];
      check8("op_latch", {2'b00, o_alu_op}, {2'b00, exp_op});
      check1("no_tmo_op", o_timeout, 1'b0);
      check1("busy_exec", o_busy, 1'b1);
      check1("start_exec", o_tx_start, 1'b0);
      exp_tx = alu_model(exp_a, exp_b, exp_op);
      start_exp++;
      tick();
      check1("start_pulse", o_tx_start, 1'b1);
      check8("tx_data", o_tx_data, exp_tx);
      tick();
      check1("start_end", o_tx_start, 1'b0);
      check1("busy_wait_tx", o_busy, 1'b1);
      if (overrun) begin
         send_byte(8'h99);
         ovr_exp++;
         check1("overrun_pulse", o_overrun, 1'b1);
         check_operands("overrun");
         tick();
         check1("overrun_end", o_overrun, 1'b0);
         check1("busy_after_ovr", o_busy, 1'b1);
      end
      idle(txw);
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      check1("busy_done", o_busy, 1'b0);
   endtask

   initial begin
      i_rst_n   = 1'b0;
      i_rx_data = 8'h00;
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_operands("reset");
      check1("reset_start", o_tx_start, 1'b0);
      check1("reset_busy", o_busy, 1'b0);
      check1("reset_tmo", o_timeout, 1'b0);
      check1("reset_ovr", o_overrun, 1'b0);
      i_rst_n = 1'b1;
      idle(2);

      // Normal command and opcode masking
      do_cmd(8'h05, 8'h03, 8'h20, 1, 1'b0, 3);
      check8("normal_tx", o_tx_data, 8'h08);
      do_cmd(8'h30, 8'h10, 8'hE2, 0, 1'b0, 0);
      check8("masked_op", {2'b00, o_alu_op}, 8'h22);
      check8("masked_tx", o_tx_data, 8'h20);

      // Timeout after operand A
      send_byte(8'h11);
      exp_a = 8'h11;
      idle(TIMEOUT - 1);
      check1("tmo_early", o_timeout, 1'b0);
      idle(1);
      check1("tmo_pulse", o_timeout, 1'b1);
      check1("tmo_busy", o_busy, 1'b0);
      tmo_exp++;
      tick();
      check1("tmo_end", o_timeout, 1'b0);
      do_cmd(8'h44, 8'h04, 8'h22, 2, 1'b0, 1);
      check8("after_tmo_tx", o_tx_data, 8'h40);

      // Byte arriving on the timer's last cycle in WAIT_B and WAIT_OP
      do_cmd(8'h55, 8'h07, 8'h20, TIMEOUT - 1, 1'b0, 0);
      check8("collision_tx", o_tx_data, 8'h5C);

      // Overrun during WAIT_TX, then a spurious tx_done in WAIT_A
      do_cmd(8'h0F, 8'hF0, 8'h25, 0, 1'b1, 2);
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      check1("spurious_txdone_busy", o_busy, 1'b0);
      check_operands("spurious_txdone");
      do_cmd(8'h81, 8'h18, 8'h26, 0, 1'b0, 0);

      // Asynchronous reset while waiting for transmit completion
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'h20);
      start_exp++;
      idle(2);
      #2;
      i_rst_n = 1'b0;
      #1;
      exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00; exp_tx = 8'h00;
      check_operands("async_rst");
      check1("async_rst_start", o_tx_start, 1'b0);
      check1("async_rst_busy", o_busy, 1'b0);
      @(negedge clk);
      i_rst_n = 1'b1;
      do_cmd(8'h02, 8'h02, 8'h20, 0, 1'b0, 0);
      check8("post_rst_tx", o_tx_data, 8'h04);

      // Randomized commands
      for (int n = 0; n < 30; n++) begin
         logic [7:0] ra, rb, ro;
         logic [2:0] sel;
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         sel = 3'($urandom_range(0, 5));
         case (sel)
            3'd0: ro = 8'h20;
            3'd1: ro = 8'h22;
            3'd2: ro = 8'h24;
            3'd3: ro = 8'h25;
            3'd4: ro = 8'h26;
            default: ro = 8'($urandom);
         endcase
         ro[7:6] = 2'($urandom);
         do_cmd(ra, rb, ro, $urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4));
      end

      idle(2);
      check_int("timeout_pulses", tmo_seen, tmo_exp);
      check_int("overrun_pulses", ovr_seen, ovr_exp);
      check_int("start_pulses", start_seen, start_exp);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
